// File: rtl/sdram_image_writer_pkg.sv
// Shared types and constants for the SDRAM image writer.
package sdram_image_writer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_e;
  localparam int PIX_PER_WORD = 16;
  localparam int PIX_W        = 2;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);
  localparam logic [3:0] BYTEEN_ALL = 4'hF;
endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous FIFO; head word comes straight from the storage registers.
// A push on a full FIFO succeeds when a pop happens in the same cycle.
module sync_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sdram_image_writer.sv
// Packs the 2-bit pixel stream into 32-bit words and writes them to SDRAM over Avalon-MM.
// Optional SDRAM_WRITER_STATS_EN adds per-frame word and stall counters.
module sdram_image_writer
  import sdram_image_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              read_image_en,
  input  logic              read_image,
  input  logic [PIX_W-1:0]  read_image_data,
  input  logic              read_image_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest
`ifdef SDRAM_WRITER_STATS_EN
  ,
  output logic [22:0]       stat_words,
  output logic [31:0]       stat_stall
`endif
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       word_q, pword_q, word_ins;
  logic              pack_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wr_q;

  logic              start_ok, accept;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [31:0]       fifo_din, fifo_dout;

  assign start_ok  = start && (state_q == S_IDLE);
  assign accept    = wr_q && !avm_waitrequest;
  // Completed words land one cycle after slot 15; FLUSH only pushes a partial word.
  assign fifo_push = pack_q || ((state_q == S_FLUSH) && (idx_q != '0));
  assign fifo_din  = pack_q ? pword_q : word_q;

  sync_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (fifo_push),
    .data_i (fifo_din),
    .pop_i  (accept),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (read_image_done) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && !wr_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    word_ins = word_q;
    word_ins[{idx_q, 1'b0} +: PIX_W] = read_image_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      word_q  <= '0;
      pword_q <= '0;
      pack_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pack_q <= 1'b0;
      if (start_ok) begin
        idx_q  <= '0;
        word_q <= '0;
        ovf_q  <= 1'b0;
      end else if ((state_q == S_RUN) && read_image) begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == IDX_W'(PIX_PER_WORD - 1)) begin
          pword_q <= word_ins;
          pack_q  <= 1'b1;
          word_q  <= '0;
        end else begin
          word_q <= word_ins;
        end
      end
      if (fifo_push && fifo_full && !accept) ovf_q <= 1'b1;
    end
  end

  // Head word stays in the FIFO until the slave accepts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (start_ok) addr_q <= base_addr;
      if (accept) begin
        wr_q   <= 1'b0;
        addr_q <= addr_q + ADDR_W'(4);
      end else if (!wr_q && !fifo_empty) begin
        wr_q    <= 1'b1;
        wdata_q <= fifo_dout;
      end
    end
  end

`ifdef SDRAM_WRITER_STATS_EN
  logic [22:0] words_q;
  logic [31:0] stall_q;
  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (accept && !(&words_q)) words_q <= words_q + 1'b1;
      if (wr_q && avm_waitrequest && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end
  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign overflow       = ovf_q;
  assign read_image_en  = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign avm_address    = addr_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = wr_q ? BYTEEN_ALL : 4'h0;
endmodule

// File: tb/tb_sdram_image_writer.sv
// Directed bench for sdram_image_writer with a frame-level write model and an Avalon monitor.
module tb_sdram_image_writer;
  logic        clock = 1'b0;
  logic        reset, start, read_image, read_image_done;
  logic [31:0] base_addr;
  logic [1:0]  read_image_data;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, overflow, read_image_en, avm_write;
  logic [31:0] avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
`ifdef SDRAM_WRITER_STATS_EN
  logic [22:0] stat_words;
  logic [31:0] stat_stall;
`endif

  sdram_image_writer #(.FIFO_DEPTH(8), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .overflow(overflow), .read_image_en(read_image_en),
    .read_image(read_image), .read_image_data(read_image_data),
    .read_image_done(read_image_done), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest)
`ifdef SDRAM_WRITER_STATS_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, stall_seen = 0, stall_limit = 0;
  logic        prev_stall = 1'b0, prev_rst = 1'b1;
  logic [31:0] held_a, held_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [1:0] pixval(input int kind, input int i);
    case (kind)
      0:       return 2'(i % 4);
      1:       return 2'b11;
      default: return 2'((i ^ (i >> 4)) & 3);
    endcase
  endfunction

  // Frame model: word k holds pixels 16k..16k+15 (pixel 0 in the low bits), zero padded,
  // written at base + 4k; only the first maxw words survive a stuck slave.
  task automatic model_frame(input logic [31:0] base, input int n, input int kind, input int maxw);
    int nw;
    logic [31:0] w;
    nw = (n + 15) / 16;
    for (int k = 0; k < nw && k < maxw; k++) begin
      w = '0;
      for (int s = 0; s < 16; s++)
        if (16*k + s < n) w[2*s +: 2] = pixval(kind, 16*k + s);
      exp_q.push_back('{base + 32'(4*k), w});
    end
  endtask

  // Slave stall control: waitrequest stays high until stall_limit stalled cycles are seen.
  always @(posedge clock) begin
    #1;
    avm_waitrequest = (stall_seen < stall_limit);
  end

  always @(negedge clock) begin
    if (prev_stall && !prev_rst) begin
      chk("hold_write", 32'(avm_write), 32'd1);
      chk("hold_addr", avm_address, held_a);
      chk("hold_data", avm_writedata, held_d);
    end
    if (avm_write) begin
      chk("byteenable", 32'(avm_byteenable), 32'hF);
      if (avm_waitrequest) stall_seen++;
      else if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", avm_address, avm_writedata);
      end else begin
        chk("wr_addr", avm_address, exp_q[0].addr);
        chk("wr_data", avm_writedata, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last_write", 32'(exp_q.size()), 32'd0);
    end
    prev_stall = avm_write && avm_waitrequest;
    held_a = avm_address;
    held_d = avm_writedata;
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("en_after_start", 32'(read_image_en), 32'd1);
    chk("ovf_clear_on_start", 32'(overflow), 32'd0);
  endtask

  task automatic feed(input int n, input int kind, input bit dwl, input int gap, input bit poke);
    for (int i = 0; i < n; i++) begin
      read_image = 1'b1;
      read_image_data = pixval(kind, i);
      if (dwl && i == n-1) read_image_done = 1'b1;
      if (poke && i == 3) begin start = 1'b1; base_addr = 32'hDEAD_0000; end
      tick();
      read_image = 1'b0; read_image_done = 1'b0; start = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    if (!dwl) begin
      read_image_done = 1'b1;
      tick();
      read_image_done = 1'b0;
    end
    tick();
    chk("en_drop_after_flush", 32'(read_image_en), 32'd0);
  endtask

  task automatic wait_idle(input int d0);
    int c = 0;
    while (busy && c < 3000) begin tick(); c++; end
    chk("idle_within_budget", 32'(busy), 32'd0);
    chk("all_writes_done", 32'(exp_q.size()), 32'd0);
    chk("one_done_pulse", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; base_addr = '0;
    read_image = 1'b0; read_image_data = '0; read_image_done = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_en", 32'(read_image_en), 0);
    chk("rst_write", 32'(avm_write), 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    reset = 1'b0;
    tick();

    // 32 pixels 0..3 repeating; a stray start mid-frame must be ignored
    model_frame(32'h1000, 32, 0, 99);
    chk("pin_e4_w0", exp_q[0].data, 32'hE4E4E4E4);
    chk("pin_e4_a1", exp_q[1].addr, 32'h1004);
    d0 = done_cnt;
    do_start(32'h1000);
    feed(32, 0, 0, 0, 1);
    chk("busy_held_after_poke", 32'(busy), 1);
    wait_idle(d0);

    // 20 pixels all 3, sparse strobes, done with the last pixel -> partial word
    model_frame(32'h2000, 20, 1, 99);
    chk("pin_full_w0", exp_q[0].data, 32'hFFFFFFFF);
    chk("pin_partial_w1", exp_q[1].data, 32'h000000FF);
    d0 = done_cnt;
    do_start(32'h2000);
    feed(20, 1, 1, 1, 0);
    wait_idle(d0);

    // 5-cycle stall on first write, address wraps past 2^32
    model_frame(32'hFFFF_FFFC, 32, 2, 99);
    chk("pin_wrap_a1", exp_q[1].addr, 32'h0);
    stall_limit = stall_seen + 5;
    d0 = done_cnt;
    do_start(32'hFFFF_FFFC);
    feed(32, 2, 0, 0, 0);
    wait_idle(d0);
`ifdef SDRAM_WRITER_STATS_EN
    chk("stat_stall", stat_stall, 32'd5);
    chk("stat_words", 32'(stat_words), 32'd2);
`endif

    // stuck slave: 9 words into an 8-deep FIFO -> last dropped, overflow
    model_frame(32'h3000, 144, 2, 8);
    chk("pin_ovf_words", 32'(exp_q.size()), 32'd8);
    stall_limit = 1 << 30;
    d0 = done_cnt;
    do_start(32'h3000);
    feed(144, 2, 0, 0, 0);
    repeat (5) tick();
    chk("overflow_set", 32'(overflow), 1);
    chk("busy_while_stuck", 32'(busy), 1);
    stall_limit = 0;
    wait_idle(d0);
    chk("overflow_sticky", 32'(overflow), 1);

    // exactly 16 pixels with done on the 16th -> one word, no empty partial
    model_frame(32'h4000, 16, 0, 99);
    d0 = done_cnt;
    do_start(32'h4000);
    feed(16, 0, 1, 0, 0);
    wait_idle(d0);

    // reset while a write is stalled mid-RUN
    stall_limit = 1 << 30;
    d0 = done_cnt;
    do_start(32'h5000);
    for (int i = 0; i < 20; i++) begin
      read_image = 1'b1; read_image_data = pixval(2, i);
      tick();
    end
    read_image = 1'b0;
    repeat (3) tick();
    chk("write_pending_pre_rst", 32'(avm_write), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_en", 32'(read_image_en), 0);
    chk("mid_rst_write", 32'(avm_write), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    stall_limit = 0;
    repeat (12) tick();
    chk("no_write_after_rst", 32'(avm_write), 0);
    chk("no_done_after_rst", 32'(done_cnt - d0), 0);

    // normal frame after the reset
    model_frame(32'h6000, 40, 2, 99);
    d0 = done_cnt;
    do_start(32'h6000);
    feed(40, 2, 0, 0, 0);
    wait_idle(d0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdram_image_writer.md
Name: sdram_image_writer

Overview:
Downstream stage of the internal SRAM image buffer. Enables the buffer read-out and packs the serial 2-bit pixel stream (16 pixels per 32-bit word, pixel 0 in bits [1:0]). Packed words go through a small FIFO and are written to external SDRAM over an Avalon-MM write master from a programmable base address. Signals completion to the frame sequencer.

Parameters:
FIFO_DEPTH, 8, packed-word FIFO entries (power of 2, >=2)
ADDR_W, 32, Avalon byte-address width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame transfer (ignored unless IDLE)
base_addr  in  ADDR_W  SDRAM byte address of first word (32-bit aligned)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last word is accepted by SDRAM
overflow  out  1  sticky; FIFO was full when a packed word had to be pushed
read_image_en  out  1  enable to SRAM buffer read-out; held high during RUN/FLUSH
read_image  in  1  pixel valid strobe
read_image_data  in  2  pixel value, valid when read_image=1
read_image_done  in  1  level; buffer has issued its final word
avm_address  out  ADDR_W  write address
avm_write  out  1  write request
avm_writedata  out  32  packed word
avm_byteenable  out  4  always 4'hF while avm_write=1
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: state IDLE; busy=0, done=0, overflow=0, read_image_en=0, avm_write=0, avm_address=0, avm_writedata=0, pixel index=0, FIFO empty.
- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE: start=1 -> latch base_addr into address counter; clear overflow and pixel index; go RUN. busy=1 from next cycle.
- RUN: read_image_en=1. Each cycle with read_image=1, store pixel at slot index (bits [2i+1:2i]); index 4-bit wrap. At slot 15 the completed word is pushed into the FIFO in the next cycle (1-cycle pack latency). read_image_done=1 -> FLUSH.
- FLUSH (1 cycle): if index!=0, push partial word with unfilled slots = 0. Drop read_image_en; go DRAIN.
- DRAIN: wait for FIFO empty and no outstanding write -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 next cycle; -> IDLE.
- Avalon master, all states: if FIFO non-empty and avm_write=0, present head word, assert avm_write. Hold address/data/write stable while avm_waitrequest=1. On avm_write=1 and avm_waitrequest=0: pop FIFO, address += 4, next word may be presented the following cycle (max 1 word / 2 cycles).
- Address arithmetic: ADDR_W unsigned, wraps modulo 2^ADDR_W silently.
- FIFO full on push: word dropped, overflow=1 sticky until next accepted start; transfer still completes (no upstream stall exists).
- Simultaneous push and pop on a full FIFO: pop first, push succeeds, no overflow.
- read_image and read_image_done in the same cycle: pixel is stored before the FLUSH decision.
- start while busy: ignored.
- reset mid-transfer: immediate return to reset values; avm_write drops even under waitrequest (an interrupted SDRAM write is acceptable).

Optional Feature:
SDRAM_WRITER_STATS_EN: adds outputs stat_words[22:0] (words accepted by SDRAM in the current/last frame) and stat_stall[31:0] (cycles with avm_write=1 and avm_waitrequest=1). Both clear on accepted start, saturate at all-ones, hold after done. Without the macro, the ports and counters do not exist.

Decomposition:
- Package sdram_image_writer_pkg: state enum, PIX_PER_WORD=16, PIX_W=2, BYTEEN_ALL=4'hF.
- Sub-module sync_word_fifo (parameterised depth/width, full/empty, registered output, push+pop same cycle). All other logic stays in the top module.

Test Plan:
- 32 pixels, values 0..3 repeating, no waitrequest, base 0x1000 -> two writes: 0x1000 data 0xE4E4E4E4, 0x1004 data 0xE4E4E4E4; done pulse once; busy low after.
- 20 pixels all 2'b11 -> words 0xFFFFFFFF and 0x000000FF (partial flush, zero pad) at base and base+4.
- waitrequest held 5 cycles on the first write -> address/data stable all 5 cycles; single pop; stat_stall=5 with SDRAM_WRITER_STATS_EN.
- waitrequest stuck high for 9 packed words (FIFO_DEPTH=8) -> overflow=1; after release, 8 words written, done still pulses; next start clears overflow.
- start during busy -> no effect; reset mid-RUN -> read_image_en=0, avm_write=0 next cycle, FIFO empty, new start works normally.
- read_image and read_image_done asserted in the same cycle on the 16th pixel -> exactly one full word written, no empty partial word.
